// File: rtl/edge_level_pkg.sv
// edge_level_pkg: mode encodings and edge-match helper shared by edge_level_detect and edge_level_chan
package edge_level_pkg;
  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_BOTH  = 2'b11
  } mode_e;
  function automatic logic edge_hit(mode_e m, logic sync, logic prev);
    return (m[0] & sync & ~prev) | (m[1] & ~sync & prev);
  endfunction
endpackage

// File: rtl/edge_level_chan.sv
// edge_level_chan: one channel (sync chain, edge/level detect, repeat timer, sticky pending, saturating count); in clk rst sig_in mode ch_en ack clr_count, out evt_pulse pending evt_count
module edge_level_chan
  import edge_level_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int LEVEL_PERIOD = 4,
  parameter int COUNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sig_in,
  input  logic [1:0]         mode,
  input  logic               ch_en,
  input  logic               ack,
  input  logic               clr_count,
  output logic               evt_pulse,
  output logic               pending,
  output logic [COUNT_W-1:0] evt_count
);
  localparam int PW = $clog2(LEVEL_PERIOD + 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  mode_e                  mode_q;
  logic [PW-1:0]          per_q, per_d, per_base;
  logic                   evt_q, evt_d;
  logic                   pend_q, pend_d;
  logic [COUNT_W-1:0]     cnt_q, cnt_d;
  logic                   sync, lvl_on;
  mode_e                  mode_n;
  always_comb begin
    sync     = sync_q[SYNC_STAGES-1];
    mode_n   = mode_e'(mode);
    per_base = (mode_n != mode_q) ? '0 : per_q;
    lvl_on   = (mode_n == MODE_LEVEL) && sync && ch_en;
    per_d    = !lvl_on ? '0 : (per_base == PW'(LEVEL_PERIOD - 1)) ? '0 : per_base + PW'(1);
    evt_d    = ch_en && ((mode_n == MODE_LEVEL) ? (lvl_on && per_base == '0) : edge_hit(mode_n, sync, prev_q));
    pend_d   = evt_q | (pend_q & ~ack);
    cnt_d    = clr_count ? COUNT_W'(evt_q) : (evt_q && !(&cnt_q)) ? cnt_q + COUNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      mode_q <= MODE_LEVEL;
      per_q  <= '0;
      evt_q  <= 1'b0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync;
      mode_q <= mode_n;
      per_q  <= per_d;
      evt_q  <= evt_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end
  assign evt_pulse = evt_q;
  assign pending   = pend_q;
  assign evt_count = cnt_q;
endmodule

// File: rtl/edge_level_detect.sv
// edge_level_detect: CH-channel edge/level event detector with sticky pending, irq and event counters; in clk rst sig_in mode ch_en ack clr_count, out evt_pulse pending irq evt_count
module edge_level_detect
  import edge_level_pkg::*;
#(
  parameter int CH           = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int LEVEL_PERIOD = 4,
  parameter int COUNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         sig_in,
  input  logic [2*CH-1:0]       mode,
  input  logic [CH-1:0]         ch_en,
  input  logic [CH-1:0]         ack,
  input  logic [CH-1:0]         clr_count,
  output logic [CH-1:0]         evt_pulse,
  output logic [CH-1:0]         pending,
  output logic                  irq,
  output logic [CH*COUNT_W-1:0] evt_count
);
  for (genvar i = 0; i < CH; i++) begin : g_ch
    edge_level_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .LEVEL_PERIOD(LEVEL_PERIOD),
      .COUNT_W     (COUNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .sig_in   (sig_in[i]),
      .mode     (mode[2*i +: 2]),
      .ch_en    (ch_en[i]),
      .ack      (ack[i]),
      .clr_count(clr_count[i]),
      .evt_pulse(evt_pulse[i]),
      .pending  (pending[i]),
      .evt_count(evt_count[i*COUNT_W +: COUNT_W])
    );
  end
  assign irq = |pending;
endmodule
